dvp_capture_win: RTL and testbench

//  Second-generation DVP camera capture for the OV5640 path. Samples vsync/href/data on the pixel clock,

---
 rtl/dvp_capture_win.sv | 246 ++++++++++++++++++++++++
 tb/tb_dvp_capture_win.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_capture_win.sv
// DVP camera capture: registers the sensor bus, packs PIX_BYTES beats per pixel, skips settle
// frames, decimates frames and crops a runtime window into a flagged pixel stream.
module dvp_capture_win #(
   parameter int DW        = 8,
   parameter int PIX_BYTES = 2,
   parameter int CNT_W     = 12,
   parameter int SKIP_FRM  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cam_vsync,
   input  logic                    cam_href,
   input  logic [DW-1:0]           cam_data,
   input  logic                    cfg_en,
   input  logic [CNT_W-1:0]        win_x0,
   input  logic [CNT_W-1:0]        win_x1,
   input  logic [CNT_W-1:0]        win_y0,
   input  logic [CNT_W-1:0]        win_y1,
   input  logic [3:0]              dec_n,
   output logic [DW*PIX_BYTES-1:0] m_data,
   output logic                    m_valid,
   output logic                    m_sof,
   output logic                    m_eol,
   output logic                    frame_done,
   output logic [15:0]             frame_cnt,
   output logic                    line_err,
   output logic [2:0]              dbg_state_o
);

   localparam int OW   = DW * PIX_BYTES;
   localparam int PH_W = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
   localparam int SK_W = (SKIP_FRM > 1) ? $clog2(SKIP_FRM + 1) : 1;
   localparam logic [PH_W-1:0]  PH_LAST = PH_W'(PIX_BYTES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Encoding is visible on dbg_state_o: IDLE=0, SYNC=1, SKIP=2, ARM=3, ACTIVE=4, DROP=5.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SYNC   = 3'd1,
      ST_SKIP   = 3'd2,
      ST_ARM    = 3'd3,
      ST_ACTIVE = 3'd4,
      ST_DROP   = 3'd5
   } state_t;

   // Input stage and edge detection on the registered copies
   logic          vs_q, hr_q, vs_p_q, hr_p_q;
   logic [DW-1:0] dat_q;
   logic          vs_rise, vs_fall, hr_rise, hr_fall;

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_q   <= 1'b0;
         hr_q   <= 1'b0;
         vs_p_q <= 1'b0;
         hr_p_q <= 1'b0;
         dat_q  <= '0;
      end else begin
         vs_q   <= cam_vsync;
         hr_q   <= cam_href;
         vs_p_q <= vs_q;
         hr_p_q <= hr_q;
         dat_q  <= cam_data;
      end
   end

   assign vs_rise = vs_q & ~vs_p_q;
   assign vs_fall = ~vs_q & vs_p_q;
   assign hr_rise = hr_q & ~hr_p_q;
   assign hr_fall = ~hr_q & hr_p_q;

   // Packing stage: phase, shift register, x/y position of each completed pixel
   logic [PH_W-1:0]  phase_q, phase_d, ph_cur;
   logic [OW-1:0]    sh_q, sh_d, sh_next;
   logic [CNT_W-1:0] x_q, x_d, x_cur, y_q, y_d;
   logic             pix_vld_q, pix_vld_d;
   logic [OW-1:0]    pix_dat_q, pix_dat_d;
   logic [CNT_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic             line_err_q, line_err_d;

   always_comb begin
      ph_cur     = hr_rise ? '0 : phase_q;
      x_cur      = hr_rise ? '0 : x_q;
      sh_next    = (sh_q << DW) | OW'(dat_q);
      phase_d    = phase_q;
      sh_d       = sh_q;
      x_d        = x_q;
      y_d        = y_q;
      pix_vld_d  = 1'b0;
      pix_dat_d  = pix_dat_q;
      pix_x_d    = pix_x_q;
      pix_y_d    = pix_y_q;
      line_err_d = 1'b0;
      if (hr_q) begin
         sh_d = sh_next;
         if (ph_cur == PH_LAST) begin
            phase_d   = '0;
            pix_vld_d = 1'b1;
            pix_dat_d = sh_next;
            pix_x_d   = x_cur;
            pix_y_d   = y_q;
            x_d       = (x_cur == CNT_MAX) ? x_cur : x_cur + CNT_W'(1);
         end else begin
            phase_d = ph_cur + PH_W'(1);
            x_d     = x_cur;
         end
      end
      // A line ending mid-pixel drops the partial bytes
      if (hr_fall) begin
         line_err_d = (phase_q != '0);
         phase_d    = '0;
         y_d        = (y_q == CNT_MAX) ? y_q : y_q + CNT_W'(1);
      end
      if (vs_rise) phase_d = '0;
      if (vs_fall) y_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q    <= '0;
         sh_q       <= '0;
         x_q        <= '0;
         y_q        <= '0;
         pix_vld_q  <= 1'b0;
         pix_dat_q  <= '0;
         pix_x_q    <= '0;
         pix_y_q    <= '0;
         line_err_q <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         sh_q       <= sh_d;
         x_q        <= x_d;
         y_q        <= y_d;
         pix_vld_q  <= pix_vld_d;
         pix_dat_q  <= pix_dat_d;
         pix_x_q    <= pix_x_d;
         pix_y_q    <= pix_y_d;
         line_err_q <= line_err_d;
      end
   end

   // Frame control FSM with registered output stage
   state_t           state_q;
   logic [SK_W-1:0]  skip_cnt_q;
   logic [3:0]       dec_cnt_q, dec_lat_q;
   logic [CNT_W-1:0] wx0_q, wx1_q, wy0_q, wy1_q;
   logic             sof_pend_q;
   logic             m_valid_q, m_sof_q, m_eol_q, frame_done_q;
   logic [OW-1:0]    m_data_q;
   logic [15:0]      frame_cnt_q;
   logic             in_win;

   assign in_win = (pix_x_q >= wx0_q) && (pix_x_q <= wx1_q) &&
                   (pix_y_q >= wy0_q) && (pix_y_q <= wy1_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         skip_cnt_q   <= '0;
         dec_cnt_q    <= '0;
         dec_lat_q    <= '0;
         wx0_q        <= '0;
         wx1_q        <= '0;
         wy0_q        <= '0;
         wy1_q        <= '0;
         sof_pend_q   <= 1'b0;
         m_valid_q    <= 1'b0;
         m_sof_q      <= 1'b0;
         m_eol_q      <= 1'b0;
         m_data_q     <= '0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         m_valid_q    <= 1'b0;
         m_sof_q      <= 1'b0;
         m_eol_q      <= 1'b0;
         frame_done_q <= 1'b0;
         if (!cfg_en) begin
            state_q    <= ST_IDLE;
            sof_pend_q <= 1'b0;
            dec_cnt_q  <= '0;
         end else begin
            if (state_q == ST_ACTIVE && pix_vld_q && in_win) begin
               m_valid_q  <= 1'b1;
               m_data_q   <= pix_dat_q;
               m_sof_q    <= sof_pend_q;
               m_eol_q    <= (pix_x_q == wx1_q);
               sof_pend_q <= 1'b0;
            end
            case (state_q)
               ST_IDLE: state_q <= ST_SYNC;
               ST_SYNC: begin
                  if (vs_rise) begin
                     skip_cnt_q <= '0;
                     state_q    <= (SKIP_FRM == 0) ? ST_ARM : ST_SKIP;
                  end
               end
               ST_SKIP: begin
                  if (vs_rise) begin
                     if (skip_cnt_q + SK_W'(1) == SK_W'(SKIP_FRM)) state_q <= ST_ARM;
                     skip_cnt_q <= skip_cnt_q + SK_W'(1);
                  end
               end
               ST_ARM: begin
                  // Window and decimation are frozen for the whole upcoming frame
                  if (vs_fall) begin
                     wx0_q      <= win_x0;
                     wx1_q      <= win_x1;
                     wy0_q      <= win_y0;
                     wy1_q      <= win_y1;
                     dec_lat_q  <= dec_n;
                     state_q    <= (dec_cnt_q == '0) ? ST_ACTIVE : ST_DROP;
                     sof_pend_q <= (dec_cnt_q == '0);
                  end
               end
               ST_ACTIVE: begin
                  if (vs_rise) begin
                     frame_done_q <= 1'b1;
                     frame_cnt_q  <= frame_cnt_q + 16'd1;
                     dec_cnt_q    <= dec_lat_q;
                     sof_pend_q   <= 1'b0;
                     state_q      <= ST_ARM;
                  end
               end
               ST_DROP: begin
                  if (vs_rise) begin
                     dec_cnt_q <= dec_cnt_q - 4'd1;
                     state_q   <= ST_ARM;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign m_data      = m_data_q;
   assign m_valid     = m_valid_q;
   assign m_sof       = m_sof_q;
   assign m_eol       = m_eol_q;
   assign frame_done  = frame_done_q;
   assign frame_cnt   = frame_cnt_q;
   assign line_err    = line_err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dvp_capture_win.sv
// Bench for dvp_capture_win: frame-level reference model predicts every emitted beat
// (cycle, data, sof, eol) plus frame_done/line_err/frame_cnt totals.
module tb_dvp_capture_win;
   localparam int DW = 8, PB = 2, CW = 12, SK = 4;
   localparam int OW = DW * PB;
   localparam int EW = 32 + OW + 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, cam_vsync, cam_href, cfg_en;
   logic [DW-1:0] cam_data;
   logic [CW-1:0] win_x0, win_x1, win_y0, win_y1;
   logic [3:0]    dec_n;
   logic [OW-1:0] m_data;
   logic          m_valid, m_sof, m_eol, frame_done, line_err;
   logic [15:0]   frame_cnt;
   logic [2:0]    dbg_state;

   dvp_capture_win #(.DW(DW), .PIX_BYTES(PB), .CNT_W(CW), .SKIP_FRM(SK)) dut (
      .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
      .cfg_en(cfg_en), .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
      .dec_n(dec_n), .m_data(m_data), .m_valid(m_valid), .m_sof(m_sof), .m_eol(m_eol),
      .frame_done(frame_done), .frame_cnt(frame_cnt), .line_err(line_err), .dbg_state_o(dbg_state)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, failures = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_obs, mon_exp;
   int exp_fd = 0, exp_le = 0, fd_seen = 0, le_seen = 0;
   int fidx, dec_cur, fx0, fx1, fy0, fy1, nlines, abort_cyc;
   int line_nb[8];
   logic [15:0] exp_fcnt = '0;
   bit sof_pend, chg_win, aborted;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output monitor: every beat must match the head of the expected queue
   always @(negedge clk) begin
      if (m_valid === 1'b1) begin
         checks++;
         mon_obs = {32'(cyc), m_data, m_sof, m_eol};
         mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
         assert (mon_obs === mon_exp) else begin
            failures++;
            $error("FAIL beat observed=%h expected=%h", mon_obs, mon_exp);
         end
      end else if (!rst) begin
         checks++;
         assert ({m_sof, m_eol} === 2'b00) else begin
            failures++;
            $error("FAIL flags_without_valid observed=%b expected=00", {m_sof, m_eol});
         end
      end
      if (frame_done === 1'b1) fd_seen++;
      if (line_err === 1'b1) le_seen++;
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         cam_href = 1'b0;
      end
   endtask

   task automatic purge_after(input int d);
      logic [EW-1:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q[exp_q.size()-1];
         if (e[EW-1 -: 32] > 32'(d)) void'(exp_q.pop_back());
         else break;
      end
   endtask

   task automatic rand_win();
      win_x0 = CW'($urandom_range(0, 9));
      win_x1 = CW'($urandom_range(0, 9));
      win_y0 = CW'($urandom_range(0, 4));
      win_y1 = CW'($urandom_range(0, 4));
   endtask

   // One line of nb bytes; pixel x completes on every PB-th byte, emitted 3 clk after its last byte
   task automatic drive_line(input int nb, input bit cap, input int y, input bit fixed_d, input int amode);
      logic [OW-1:0] acc;
      logic [DW-1:0] b;
      int x;
      acc = '0;
      for (int i = 0; i < nb; i++) begin
         @(negedge clk);
         b = fixed_d ? ((i % 2 == 0) ? 8'h12 : 8'h34) : DW'($urandom);
         cam_href = 1'b1;
         cam_data = b;
         acc = (acc << DW) | OW'(b);
         if ((i + 1) % PB == 0) begin
            x = (i + 1) / PB - 1;
            if (cap && x >= fx0 && x <= fx1 && y >= fy0 && y <= fy1) begin
               exp_q.push_back({32'(cyc + 3), acc, sof_pend, (x == fx1)});
               sof_pend = 1'b0;
            end
         end
      end
      @(negedge clk);
      cam_href = 1'b0;
      if (amode != 0) begin
         abort_cyc = cyc;
         if (amode == 1) cfg_en = 1'b0;
         else rst = 1'b1;
         purge_after(abort_cyc);
         aborted = 1'b1;
         return;
      end
      if (nb % PB != 0) exp_le++;
      idle(3);
   endtask

   task automatic drive_frame(input bit fixed_d, input int amode);
      bit cap;
      fidx++;
      cap = (fidx > SK) && ((fidx - SK - 1) % (dec_cur + 1) == 0);
      @(negedge clk);
      cam_vsync = 1'b1;
      idle(2);
      @(negedge clk);
      cam_vsync = 1'b0;
      fx0 = int'(win_x0); fx1 = int'(win_x1); fy0 = int'(win_y0); fy1 = int'(win_y1);
      sof_pend = cap;
      idle(3);
      for (int l = 0; l < nlines; l++) begin
         drive_line((l == 1 && amode != 0) ? 6 : line_nb[l], cap, l, fixed_d, (l == 1) ? amode : 0);
         if (aborted) return;
         if (l == 0 && chg_win) rand_win();
      end
      if (cap) begin
         exp_fd++;
         exp_fcnt++;
      end
   endtask

   task automatic start_scn(input int x0, input int x1, input int y0, input int y1, input int dec);
      @(negedge clk);
      cfg_en = 1'b0;
      idle(3);
      win_x0 = CW'(x0); win_x1 = CW'(x1); win_y0 = CW'(y0); win_y1 = CW'(y1);
      dec_n = 4'(dec);
      dec_cur = dec;
      fidx = 0;
      @(negedge clk);
      cfg_en = 1'b1;
      idle(3);
   endtask

   task automatic end_scn(input string tag);
      @(negedge clk);
      cam_vsync = 1'b1;
      idle(4);
      @(negedge clk);
      cfg_en = 1'b0;
      idle(2);
      @(negedge clk);
      cam_vsync = 1'b0;
      idle(3);
      check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
      check({tag, "_frame_done"}, 64'(fd_seen), 64'(exp_fd));
      check({tag, "_line_err"}, 64'(le_seen), 64'(exp_le));
      check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_fcnt));
      check({tag, "_state_idle"}, 64'(dbg_state), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
      check({tag, "_m_data"}, 64'(m_data), 64'd0);
      check({tag, "_m_sof"}, 64'(m_sof), 64'd0);
      check({tag, "_m_eol"}, 64'(m_eol), 64'd0);
      check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
      check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
      check({tag, "_line_err"}, 64'(line_err), 64'd0);
      check({tag, "_state"}, 64'(dbg_state), 64'd0);
   endtask

   initial begin
      rst = 1'b1; cfg_en = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = '0;
      win_x0 = '0; win_x1 = '0; win_y0 = '0; win_y1 = '0; dec_n = '0;
      chg_win = 1'b0; aborted = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // 8x4 frames of 0x12,0x34 after settle; frames 5 and 6 captured
      nlines = 4;
      for (int l = 0; l < 8; l++) line_nb[l] = 16;
      start_scn(0, 7, 0, 3, 0);
      repeat (6) drive_frame(1'b1, 0);
      end_scn("full");

      // Crop window (2,5,1,2)
      start_scn(2, 5, 1, 2, 0);
      repeat (5) drive_frame(1'b0, 0);
      end_scn("crop");

      // Decimation by 3: settle + 9 frames, frames 1,4,7 captured
      nlines = 2;
      start_scn(0, 7, 0, 3, 2);
      repeat (SK + 9) drive_frame(1'b0, 0);
      end_scn("dec");

      // Short line of 3 bytes in every frame
      nlines = 4;
      line_nb[1] = 3;
      start_scn(0, 7, 0, 3, 0);
      repeat (5) drive_frame(1'b0, 0);
      end_scn("short_line");

      // Randomized geometry, windows (incl. empty ones, changed mid-frame) and decimation
      chg_win = 1'b1;
      for (int s = 0; s < 3; s++) begin
         nlines = $urandom_range(2, 5);
         for (int l = 0; l < 8; l++) line_nb[l] = $urandom_range(1, 18);
         start_scn($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 4),
                   $urandom_range(0, 4), $urandom_range(0, 2));
         repeat (SK + $urandom_range(1, 4)) drive_frame(1'b0, 0);
         end_scn("random");
      end
      chg_win = 1'b0;

      // cfg_en dropped mid-line of a captured frame
      nlines = 4;
      for (int l = 0; l < 8; l++) line_nb[l] = 16;
      start_scn(0, 7, 0, 3, 0);
      repeat (SK) drive_frame(1'b0, 0);
      aborted = 1'b0;
      drive_frame(1'b0, 1);
      @(negedge clk);
      check("cfg_abort_m_valid", 64'(m_valid), 64'd0);
      check("cfg_abort_state", 64'(dbg_state), 64'd0);
      check("cfg_abort_frame_cnt", 64'(frame_cnt), 64'(exp_fcnt));
      aborted = 1'b0;
      idle(6);
      check("cfg_abort_queue", 64'(exp_q.size()), 64'd0);
      check("cfg_abort_frame_done", 64'(fd_seen), 64'(exp_fd));

      // Synchronous reset mid-frame
      start_scn(0, 7, 0, 3, 0);
      repeat (SK) drive_frame(1'b0, 0);
      drive_frame(1'b0, 2);
      @(negedge clk);
      check_all_zero("rst_abort");
      exp_fcnt = '0;
      rst = 1'b0;
      aborted = 1'b0;
      cfg_en = 1'b0;
      idle(6);
      check("rst_abort_queue", 64'(exp_q.size()), 64'd0);
      check("rst_abort_frame_done", 64'(fd_seen), 64'(exp_fd));
      check("rst_abort_line_err", 64'(le_seen), 64'(exp_le));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
